// File: rtl/exe_pkg.sv
// rtl/exe_pkg.sv - shared widths, ALU opcodes and multiplier states for the EX stage
package exe_pkg;

   localparam int DATA_W = 24;
   localparam int REG_AW = 4;

   typedef enum logic [3:0] {
      EXE_ADD = 4'd0,
      EXE_SUB = 4'd1,
      EXE_AND = 4'd2,
      EXE_OR  = 4'd3,
      EXE_XOR = 4'd4,
      EXE_SHL = 4'd5,
      EXE_SHR = 4'd6,
      EXE_MOV = 4'd7,
      EXE_MUL = 4'd8,
      EXE_CMP = 4'd9,
      EXE_NOP = 4'd15
   } exe_cmd_t;

   typedef enum logic [1:0] {
      MUL_IDLE = 2'd0,
      MUL_BUSY = 2'd1,
      MUL_DONE = 2'd2
   } mul_state_t;

endpackage

// File: rtl/seq_multiplier.sv
// rtl/seq_multiplier.sv - iterative shift-add multiplier, one partial product per cycle
module seq_multiplier
   import exe_pkg::*;
#(
   parameter int WIDTH      = DATA_W,
   parameter int MUL_CYCLES = DATA_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] product
);

   localparam int CNT_W = $clog2(MUL_CYCLES);

   mul_state_t       r_state;
   mul_state_t       w_next;
   logic [WIDTH-1:0] r_mcand;
   logic [WIDTH-1:0] r_mplier;
   logic [WIDTH-1:0] r_acc;
   logic [CNT_W-1:0] r_cnt;

   // state register
   always_ff @(posedge clk) begin
      if (rst) r_state <= MUL_IDLE;
      else     r_state <= w_next;
   end

   // next state; busy covers the launch cycle so the front of the pipe stalls immediately
   always_comb begin
      w_next = r_state;
      busy   = 1'b0;
      done   = 1'b0;
      case (r_state)
         MUL_IDLE: begin
            if (start) begin
               busy   = 1'b1;
               w_next = MUL_BUSY;
            end
         end
         MUL_BUSY: begin
            busy = 1'b1;
            if (r_cnt == CNT_W'(MUL_CYCLES - 1)) w_next = MUL_DONE;
         end
         MUL_DONE: begin
            done   = 1'b1;
            w_next = MUL_IDLE;
         end
         default: w_next = MUL_IDLE;
      endcase
   end

   // operand latch on launch, then one shift-add step per busy cycle
   always_ff @(posedge clk) begin
      if (rst) begin
         r_mcand  <= '0;
         r_mplier <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
      end else begin
         case (r_state)
            MUL_IDLE: begin
               if (start) begin
                  r_mcand  <= a;
                  r_mplier <= b;
                  r_acc    <= '0;
                  r_cnt    <= '0;
               end
            end
            MUL_BUSY: begin
               if (r_mplier[0]) r_acc <= r_acc + r_mcand;
               r_mcand  <= r_mcand << 1;
               r_mplier <= r_mplier >> 1;
               r_cnt    <= r_cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

   assign product = r_acc;

endmodule

// File: rtl/execute_stage.sv
// rtl/execute_stage.sv - EX stage: ALU, multiplier, EX/MEM register, flags; EXE_FWD_EN enables MEM/WB forwarding
module execute_stage
   import exe_pkg::*;
#(
   parameter int MUL_CYCLES = 24
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [3:0]        exe_cmd,
   input  logic [DATA_W-1:0] val1,
   input  logic [DATA_W-1:0] val2,
   input  logic              val2_is_reg,
   input  logic [DATA_W-1:0] st_in,
   input  logic [REG_AW-1:0] src1,
   input  logic [REG_AW-1:0] src2,
   input  logic [REG_AW-1:0] dest_in,
   input  logic              mem_r_en_in,
   input  logic              mem_w_en_in,
   input  logic              wb_en_in,
   input  logic              br_taken_in,
   input  logic [REG_AW-1:0] wb_dest,
   input  logic [DATA_W-1:0] wb_value,
   input  logic              wb_en_wb,
   output logic              stall,
   output logic [DATA_W-1:0] alu_result,
   output logic [DATA_W-1:0] st_val,
   output logic [REG_AW-1:0] dest_out,
   output logic              mem_r_en,
   output logic              mem_w_en,
   output logic              wb_en,
   output logic              br_taken,
   output logic              flag_z,
   output logic              flag_n
);

   exe_cmd_t          w_cmd;
   logic [DATA_W-1:0] w_a;
   logic [DATA_W-1:0] w_b;
   logic [DATA_W-1:0] w_st;
   logic [DATA_W-1:0] w_alu;
   logic              w_defined;
   logic              w_mul_busy;
   logic              w_mul_done;
   logic [DATA_W-1:0] w_mul_product;
   logic [4:0]        w_shamt;

   logic [DATA_W-1:0] r_alu_result;
   logic [DATA_W-1:0] r_st_val;
   logic [REG_AW-1:0] r_dest;
   logic              r_mem_r_en;
   logic              r_mem_w_en;
   logic              r_wb_en;
   logic              r_br_taken;
   logic              r_flag_z;
   logic              r_flag_n;

   assign w_cmd   = exe_cmd_t'(exe_cmd);
   assign w_shamt = w_b[4:0];

`ifdef EXE_FWD_EN
   // a load in MEM has no data yet, so it must not be forwarded from this register
   logic w_mem_fwd_ok;
   assign w_mem_fwd_ok = r_wb_en && !r_mem_r_en;
   assign w_a  = (w_mem_fwd_ok && r_dest == src1) ? r_alu_result :
                 (wb_en_wb && wb_dest == src1)    ? wb_value     : val1;
   assign w_b  = !val2_is_reg                     ? val2         :
                 (w_mem_fwd_ok && r_dest == src2) ? r_alu_result :
                 (wb_en_wb && wb_dest == src2)    ? wb_value     : val2;
   assign w_st = (w_mem_fwd_ok && r_dest == src2) ? r_alu_result :
                 (wb_en_wb && wb_dest == src2)    ? wb_value     : st_in;
`else
   logic w_unused_fwd;
   assign w_unused_fwd = ^{src1, src2, val2_is_reg, wb_dest, wb_value, wb_en_wb};
   assign w_a  = val1;
   assign w_b  = val2;
   assign w_st = st_in;
`endif

   seq_multiplier #(
      .WIDTH      (DATA_W),
      .MUL_CYCLES (MUL_CYCLES)
   ) u_mul (
      .clk     (clk),
      .rst     (rst),
      .start   (w_cmd == EXE_MUL),
      .a       (w_a),
      .b       (w_b),
      .busy    (w_mul_busy),
      .done    (w_mul_done),
      .product (w_mul_product)
   );

   assign stall = w_mul_busy && !rst;

   // single-cycle ALU; MUL only reaches the register in the multiplier's done cycle
   always_comb begin
      w_alu     = '0;
      w_defined = 1'b1;
      case (w_cmd)
         EXE_ADD: w_alu = w_a + w_b;
         EXE_SUB: w_alu = w_a - w_b;
         EXE_AND: w_alu = w_a & w_b;
         EXE_OR:  w_alu = w_a | w_b;
         EXE_XOR: w_alu = w_a ^ w_b;
         EXE_SHL: w_alu = (w_shamt >= 5'd24) ? '0 : (w_a << w_shamt);
         EXE_SHR: w_alu = (w_shamt >= 5'd24) ? '0 : (w_a >> w_shamt);
         EXE_MOV: w_alu = w_b;
         EXE_MUL: w_alu = w_mul_done ? w_mul_product : '0;
         EXE_CMP: w_alu = w_a - w_b;
         default: w_defined = 1'b0;
      endcase
   end

   // EX/MEM pipeline register; a stall inserts a bubble
   always_ff @(posedge clk) begin
      if (rst || stall) begin
         r_alu_result <= '0;
         r_st_val     <= '0;
         r_dest       <= '0;
         r_mem_r_en   <= 1'b0;
         r_mem_w_en   <= 1'b0;
         r_wb_en      <= 1'b0;
         r_br_taken   <= 1'b0;
      end else begin
         r_alu_result <= w_alu;
         r_st_val     <= w_st;
         r_dest       <= dest_in;
         r_mem_r_en   <= w_defined && mem_r_en_in;
         r_mem_w_en   <= w_defined && mem_w_en_in;
         r_wb_en      <= w_defined && wb_en_in && (w_cmd != EXE_CMP);
         r_br_taken   <= w_defined && br_taken_in;
      end
   end

   // Z/N flags follow only arithmetic compares and add/sub results
   always_ff @(posedge clk) begin
      if (rst) begin
         r_flag_z <= 1'b0;
         r_flag_n <= 1'b0;
      end else if (!stall && (w_cmd == EXE_ADD || w_cmd == EXE_SUB || w_cmd == EXE_CMP)) begin
         r_flag_z <= (w_alu == '0);
         r_flag_n <= w_alu[DATA_W-1];
      end
   end

   assign alu_result = r_alu_result;
   assign st_val     = r_st_val;
   assign dest_out   = r_dest;
   assign mem_r_en   = r_mem_r_en;
   assign mem_w_en   = r_mem_w_en;
   assign wb_en      = r_wb_en;
   assign br_taken   = r_br_taken;
   assign flag_z     = r_flag_z;
   assign flag_n     = r_flag_n;

endmodule

// File: tb/tb_execute_stage.sv
// tb/tb_execute_stage.sv - self-checking bench for execute_stage
module tb_execute_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  exe_cmd;
   logic [23:0] val1, val2, st_in, wb_value;
   logic        val2_is_reg;
   logic [3:0]  src1, src2, dest_in, wb_dest;
   logic        mem_r_en_in, mem_w_en_in, wb_en_in, br_taken_in, wb_en_wb;
   logic        stall;
   logic [23:0] alu_result, st_val;
   logic [3:0]  dest_out;
   logic        mem_r_en, mem_w_en, wb_en, br_taken, flag_z, flag_n;

   int checks   = 0;
   int failures = 0;
   bit started  = 1'b0;

   // model of the EX/MEM register contents
   logic [23:0] m_res = '0, m_st = '0, mul_prod = '0;
   logic [3:0]  m_dest = '0;
   logic        m_mr = 1'b0, m_mw = 1'b0, m_wb = 1'b0, m_br = 1'b0, m_z = 1'b0, m_n = 1'b0;
   int          mul_k = 0;

   always #5 clk = ~clk;

   execute_stage dut (
      .clk(clk), .rst(rst), .exe_cmd(exe_cmd), .val1(val1), .val2(val2),
      .val2_is_reg(val2_is_reg), .st_in(st_in), .src1(src1), .src2(src2),
      .dest_in(dest_in), .mem_r_en_in(mem_r_en_in), .mem_w_en_in(mem_w_en_in),
      .wb_en_in(wb_en_in), .br_taken_in(br_taken_in), .wb_dest(wb_dest),
      .wb_value(wb_value), .wb_en_wb(wb_en_wb), .stall(stall),
      .alu_result(alu_result), .st_val(st_val), .dest_out(dest_out),
      .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .wb_en(wb_en),
      .br_taken(br_taken), .flag_z(flag_z), .flag_n(flag_n)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [23:0] alu_model(input int cmd, input logic [23:0] a, input logic [23:0] b);
      int     sh = int'(b) % 32;
      longint la = longint'(a);
      longint lb = longint'(b);
      case (cmd)
         0:       return 24'(la + lb);
         1, 9:    return 24'(la - lb);
         2:       return a & b;
         3:       return a | b;
         4:       return a ^ b;
         5:       return (sh >= 24) ? 24'd0 : 24'(la * (longint'(1) << sh));
         6:       return (sh >= 24) ? 24'd0 : 24'(la / (longint'(1) << sh));
         7:       return b;
         default: return 24'd0;
      endcase
   endfunction

   function automatic logic [23:0] fwd(input logic [3:0] src, input logic [23:0] raw);
      logic [23:0] v = raw;
`ifdef EXE_FWD_EN
      if (m_wb && !m_mr && m_dest == src)  v = m_res;
      else if (wb_en_wb && wb_dest == src) v = wb_value;
`endif
      if (src === 4'bx) v = raw;
      return v;
   endfunction

   function automatic logic exp_stall();
      if (rst) return 1'b0;
      if (mul_k >= 1 && mul_k <= 24) return 1'b1;
      if (mul_k == 25) return 1'b0;
      return exe_cmd == 4'd8;
   endfunction

   task automatic bubble();
      m_res = '0; m_st = '0; m_dest = '0;
      m_mr = 1'b0; m_mw = 1'b0; m_wb = 1'b0; m_br = 1'b0;
   endtask

   // advance the model by one clock edge using the inputs the DUT saw at that edge
   task automatic model_step();
      logic [23:0] a, b, s, r;
      longint      p;
      int          cmd = int'(exe_cmd);
      bit          def = (cmd <= 9);
      a = fwd(src1, val1);
      b = val2_is_reg ? fwd(src2, val2) : val2;
      s = fwd(src2, st_in);
      if (rst) begin
         bubble(); m_z = 1'b0; m_n = 1'b0; mul_k = 0;
      end else if (mul_k == 0 && cmd == 8) begin
         p = longint'(a) * longint'(b);
         mul_prod = p[23:0];
         bubble(); mul_k = 1;
      end else if (mul_k >= 1 && mul_k <= 24) begin
         bubble(); mul_k++;
      end else begin
         if (mul_k == 25) begin r = mul_prod; mul_k = 0; end
         else r = alu_model(cmd, a, b);
         m_res = r; m_st = s; m_dest = dest_in;
         m_wb = def && wb_en_in && cmd != 9;
         m_mr = def && mem_r_en_in; m_mw = def && mem_w_en_in; m_br = def && br_taken_in;
         if (cmd == 0 || cmd == 1 || cmd == 9) begin m_z = (r == 24'd0); m_n = r[23]; end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      started = 1'b1;
      #1;
   endtask

   task automatic op(input logic [3:0] cmd, input logic [23:0] v1, input logic [23:0] v2, input logic [3:0] dst);
      exe_cmd = cmd; val1 = v1; val2 = v2; dest_in = dst;
      wb_en_in = 1'b1; mem_r_en_in = 1'b0; mem_w_en_in = 1'b0; br_taken_in = 1'b0;
      st_in = '0; src1 = 4'd14; src2 = 4'd15; val2_is_reg = 1'b0;
      wb_en_wb = 1'b0; wb_dest = 4'd13; wb_value = '0;
   endtask

   task automatic run_mul(input logic [23:0] a, input logic [23:0] b, input logic [23:0] exp, input string name);
      int n = 0;
      op(4'd8, a, b, 4'd3);
      #1;
      while (stall === 1'b1 && n < 40) begin
         n++;
         tick();
         #1;
      end
      tick();
      chk({name, "_stall_cycles"}, n, 25);
      chk({name, "_result"}, alu_result, {8'd0, exp});
      chk({name, "_wb_en"}, wb_en, 1);
   endtask

   // per-cycle comparison of every output against the model
   always @(negedge clk) begin
      if (started) begin
         chk("cyc_stall", stall, exp_stall());
         chk("cyc_alu_result", alu_result, m_res);
         chk("cyc_st_val", st_val, m_st);
         chk("cyc_dest_out", dest_out, m_dest);
         chk("cyc_ctrl", {mem_r_en, mem_w_en, wb_en, br_taken}, {m_mr, m_mw, m_wb, m_br});
         chk("cyc_flags", {flag_z, flag_n}, {m_z, m_n});
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      rst = 1'b1;
      op(4'd15, 0, 0, 0);
      tick(); tick();
      chk("reset_result", alu_result, 0);
      chk("reset_stall", stall, 0);
      rst = 1'b0;

      op(4'd0, 24'd5, 24'd3, 4'd1); tick();
      chk("add_5_3", alu_result, 24'd8);
      op(4'd1, 24'h000005, 24'h000007, 4'd2); tick();
      chk("sub_result", alu_result, 24'hFFFFFE);
      chk("sub_flags_zn", {flag_z, flag_n}, 2'b01);
      op(4'd9, 24'd9, 24'd9, 4'd3); tick();
      chk("cmp_flag_z", flag_z, 1);
      chk("cmp_wb_en", wb_en, 0);

      op(4'd5, 24'h000001, 24'd23, 4'd4); tick();
      chk("shl_23", alu_result, 24'h800000);
      chk("shl_flags_held", flag_z, 1);
      op(4'd5, 24'h000001, 24'd24, 4'd4); tick();
      chk("shl_24", alu_result, 24'h000000);
      op(4'd6, 24'h800000, 24'd4, 4'd4); tick();
      chk("shr_4", alu_result, 24'h080000);

      op(4'd2, 24'hF0F0F0, 24'h0FF0FF, 4'd5); tick();
      op(4'd3, 24'hF00000, 24'h00000F, 4'd5); tick();
      op(4'd4, 24'hFFFFFF, 24'h0F0F0F, 4'd5); tick();
      op(4'd7, 24'd0, 24'h123456, 4'd6); tick();
      op(4'd0, 24'h100, 24'h4, 4'd7); wb_en_in = 1'b0; mem_w_en_in = 1'b1; st_in = 24'hABCDEF; tick();
      chk("store_st_val", st_val, 24'hABCDEF);
      op(4'd1, 24'h10, 24'h10, 4'd0); br_taken_in = 1'b1; tick();
      op(4'd12, 24'h10, 24'h10, 4'd2); mem_r_en_in = 1'b1; br_taken_in = 1'b1; tick();
      chk("undef_enables", {mem_r_en, mem_w_en, wb_en, br_taken}, 0);
      op(4'd15, 24'h10, 24'h10, 4'd2); tick();

      run_mul(24'h001234, 24'h000100, 24'h123400, "mul_a");
      run_mul(24'd7, 24'd6, 24'd42, "mul_b2b");
      run_mul(24'd0, 24'h000123, 24'd0, "mul_zero");
      op(4'd0, 24'd1, 24'd1, 4'd1); tick();

      op(4'd8, 24'd3, 24'd3, 4'd3); #1;
      for (int i = 0; i < 5; i++) tick();
      rst = 1'b1; #1;
      chk("rst_gates_stall", stall, 0);
      tick(); tick();
      chk("rst_mid_mul_result", alu_result, 0);
      chk("rst_mid_mul_wb_en", wb_en, 0);
      op(4'd0, 24'd5, 24'd3, 4'd1); rst = 1'b0; tick();
      chk("add_after_rst", alu_result, 24'd8);

      op(4'd0, 24'd2, 24'd3, 4'd1); tick();
      op(4'd0, 24'd0, 24'd1, 4'd2); src1 = 4'd1; tick();
`ifdef EXE_FWD_EN
      chk("fwd_mem_a", alu_result, 24'd6);
`else
      chk("nofwd_stale_a", alu_result, 24'd1);
`endif
      op(4'd0, 24'd10, 24'd0, 4'd1); tick();
      op(4'd0, 24'd0, 24'd0, 4'd2); src1 = 4'd1; wb_en_wb = 1'b1; wb_dest = 4'd1; wb_value = 24'd99; tick();
`ifdef EXE_FWD_EN
      chk("fwd_mem_over_wb", alu_result, 24'd10);
`else
      chk("nofwd_mem_wb", alu_result, 24'd0);
`endif
      op(4'd0, 24'd4, 24'd4, 4'd1); mem_r_en_in = 1'b1; tick();
      op(4'd0, 24'd0, 24'd0, 4'd2); src1 = 4'd1; wb_en_wb = 1'b1; wb_dest = 4'd1; wb_value = 24'h77; tick();
`ifdef EXE_FWD_EN
      chk("fwd_load_uses_wb", alu_result, 24'h77);
`else
      chk("nofwd_load", alu_result, 24'd0);
`endif
      op(4'd0, 24'h10, 24'd0, 4'd1); tick();
      op(4'd0, 24'd1, 24'd0, 4'd2); val2_is_reg = 1'b1; src2 = 4'd1; mem_w_en_in = 1'b1; tick();
      op(4'd8, 24'd2, 24'd5, 4'd3); #1;
      for (int i = 0; i < 30 && stall === 1'b1; i++) tick();
      tick();
      op(4'd15, 0, 0, 0); tick(); tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/execute_stage.md
Name: execute_stage

Overview:
- EX stage of the 24-bit pipeline. Consumes the ID/EX register outputs and produces the registered EX/MEM pipeline register.
- Contains:
  - single-cycle ALU
  - iterative shift-add multiplier, which stalls the front of the pipe while busy
  - optional forwarding from MEM/WB
  - Z/N flag register
- The stall output freezes PC, IF/ID and ID/EX.

Parameters:
- DATA_W, 24: datapath width.
- REG_AW, 4: register address width.
- MUL_CYCLES, 24: multiplier iterations; must equal DATA_W.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- exe_cmd  in  4  ALU op (exe_pkg encoding)
- val1  in  24  operand A
- val2  in  24  operand B (register or immediate)
- val2_is_reg  in  1  val2 came from register src2
- st_in  in  24  store data (register src2)
- src1, src2  in  4  source register numbers
- dest_in  in  4  destination register
- mem_r_en_in, mem_w_en_in, wb_en_in, br_taken_in  in  1  control fields
- wb_dest  in  4  WB-stage destination
- wb_value  in  24  WB-stage result
- wb_en_wb  in  1  WB-stage write enable
- stall  out  1  hold upstream stages (combinational)
- alu_result  out  24  registered result
- st_val  out  24  registered store data
- dest_out  out  4  registered destination
- mem_r_en, mem_w_en, wb_en, br_taken  out  1  registered control fields
- flag_z, flag_n  out  1  registered flags

Behaviour:
- Reset (synchronous, rst=1 at posedge):
  - all registered outputs go to 0.
  - FSM goes to IDLE; iteration counter, accumulator and multiplicand are cleared.
  - stall=0 while rst=1.
  - A reset during a multiply aborts it with no writeback.
- ALU ops, results truncated to 24 bits:
  - ADD=0: A+B.
  - SUB=1: A-B.
  - AND=2, OR=3, XOR=4: bitwise.
  - SHL=5: A<<B[4:0]. SHR=6: logical A>>B[4:0]. Shift amount >=24 gives 0.
  - MOV=7: B.
  - MUL=8: low 24 bits of A*B.
  - CMP=9: computes A-B; updates flags; forces registered wb_en=0.
  - NOP=15 and undefined codes: result 0, all enables 0.
- Flags:
  - flag_z = (result==0); flag_n = result[23].
  - Updated only on ADD, SUB and CMP when the stage advances; otherwise held.
- Latency:
  - non-MUL ops: 1 cycle. Inputs at edge N appear on outputs after edge N+1.
  - store data st_val and all control fields pass through with the same latency.
- Multiplier FSM, states IDLE, BUSY, DONE:
  - IDLE and exe_cmd==MUL: stall=1; latch operands; counter=0; go to BUSY.
  - BUSY: stall=1. Each cycle, if multiplier bit0 is 1, acc += multiplicand; then multiplicand <<= 1 and multiplier >>= 1; counter++. At counter==MUL_CYCLES-1, go to DONE.
  - DONE: stall=0. The EX/MEM register captures acc with the MUL's control fields. Go to IDLE unconditionally; a following MUL is therefore a new op.
  - Total: MUL_CYCLES+1 stall cycles; result registered MUL_CYCLES+2 edges after the MUL enters.
- While stall=1: the EX/MEM register loads a bubble (wb_en, mem_r_en, mem_w_en, br_taken = 0; data = 0). Flags are held.
- Zero-operand MUL: still takes full latency; result 0.

Optional Feature:
- Macro: EXE_FWD_EN.
- Defined:
  - Operand A: forward from this block's registered alu_result when wb_en && !mem_r_en && dest_out==src1. Otherwise forward wb_value when wb_en_wb && wb_dest==src1. MEM has priority over WB.
  - Same rule for operand B, only when val2_is_reg=1; same rule for st_in vs src2.
  - Forwarded values are also what the multiplier latches.
- Undefined: val1, val2 and st_in are used unmodified. Hazards are the decoder's responsibility.

Decomposition:
- Package exe_pkg: DATA_W, REG_AW, exe_cmd_t enum (values above), mul_state_t (IDLE, BUSY, DONE).
- Sub-module seq_multiplier (clk, rst, start, a, b, busy, done, product) holds the FSM, counter and accumulator.
- execute_stage contains the ALU, forwarding muxes, EX/MEM register and stall logic.

Test Plan:
- Reset: rst held 2 cycles during a BUSY multiply -> all outputs 0, stall=0, next op ADD 5+3 gives alu_result=8 one edge later.
- SUB then CMP:
  - SUB 0x000005-0x000007 -> alu_result=0xFFFFFE, flag_n=1, flag_z=0.
  - CMP 9,9 -> flag_z=1, wb_en=0.
- Shifts: SHL 0x000001 by 23 -> 0x800000; by 24 -> 0; SHR 0x800000 by 4 -> 0x080000.
- MUL 0x001234*0x000100:
  - stall=1 for exactly 25 cycles with bubbles on EX/MEM.
  - alu_result=0x123400 with wb_en=1.
  - back-to-back MUL restarts correctly.
- EXE_FWD_EN forwarding:
  - ADD r1=2+3, then ADD r2=r1+1 with stale val1=0 -> result 6.
  - MEM hit on r1 plus a simultaneous WB hit on r1 -> MEM value selected.
  - With mem_r_en=1 in MEM -> WB value used.
